// File: rtl/btn_symbol_capture.sv
// Player button front end: synchronize/debounce three buttons, encode one press per arm cycle.
// Optional player timeout is built when BTN_CAPTURE_TIMEOUT_EN is defined.

module btn_symbol_capture_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values, which is what
    // makes the two-stage synchronizer a real two-stage shift rather than a single wire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive disagreeing samples, including this one.
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module btn_symbol_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       arm,
    output logic       sym_valid,
    output logic [1:0] sym,
    input  logic       sym_ready,
    output logic       sym_timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        HOLD,
        WAIT_RELEASE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] deb;
    logic [2:0] deb_prev;
    logic       press;
    logic       to_fire;
    logic       timeout_q;
    logic       valid_d;
    logic [1:0] sym_d;
    logic       busy_d;

    always_ff @(posedge clock) begin
        assert (DEBOUNCE_CYCLES >= 1 && TIMEOUT_CYCLES >= 1);
    end

    for (genvar i = 0; i < 3; i++) begin : g_deb
        btn_symbol_capture_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock(clock),
            .reset(reset),
            .raw  (btn[i]),
            .level(deb[i])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_prev <= 3'b000;
        end else begin
            deb_prev <= deb;
        end
    end

    // A press is the first debounced activity after all buttons were released.
    assign press = (deb_prev == 3'b000) && (deb != 3'b000);

    function automatic logic [1:0] encode(input logic [2:0] v);
        case (v)
            3'b001:  encode = 2'b00;
            3'b010:  encode = 2'b01;
            3'b100:  encode = 2'b10;
            default: encode = 2'b11;
        endcase
    endfunction

`ifdef BTN_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          timeout_d;

    // Held at zero outside WAIT_PRESS, so it starts from zero on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state_q != WAIT_PRESS) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_fire = (state_q == WAIT_PRESS) && (to_cnt == TO_LAST);

    always_comb begin
        timeout_d = timeout_q;
        if (!arm) begin
            timeout_d = 1'b0;
        end else if (state_q == WAIT_PRESS) begin
            timeout_d = !press && to_fire;
        end else if (state_q == HOLD && sym_ready) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`else
    assign to_fire   = 1'b0;
    assign timeout_q = 1'b0;
`endif

    assign sym_timeout = timeout_q;

    // NOTE: every always_comb output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        valid_d = sym_valid;
        sym_d   = sym;
        if (!arm) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = (deb == 3'b000) ? WAIT_PRESS : WAIT_RELEASE;
                end
                WAIT_PRESS: begin
                    if (press) begin
                        sym_d   = encode(deb);
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else if (to_fire) begin
                        sym_d   = 2'b11;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (sym_ready) begin
                        valid_d = 1'b0;
                        // A timeout symbol has no buttons to wait on.
                        state_d = timeout_q ? WAIT_PRESS : WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (deb == 3'b000) begin
                        state_d = WAIT_PRESS;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sym_valid <= 1'b0;
            sym       <= 2'b00;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_valid <= valid_d;
            sym       <= sym_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_btn_symbol_capture.sv
// Directed bench for btn_symbol_capture (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16).
// Timeout steps are exercised when BTN_CAPTURE_TIMEOUT_EN is defined.

module tb_btn_symbol_capture;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn;
    logic       arm;
    logic       sym_valid;
    logic [1:0] sym;
    logic       sym_ready;
    logic       sym_timeout;
    logic       busy;

    int vectors;
    int miscompares;

    btn_symbol_capture #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .btn        (btn),
        .arm        (arm),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .sym_ready  (sym_ready),
        .sym_timeout(sym_timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {busy, sym_timeout, sym_valid} for compact comparisons.
    function automatic logic [3:0] flags();
        return {1'b0, busy, sym_timeout, sym_valid};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn         = 3'b000;
        arm         = 1'b0;
        sym_ready   = 1'b0;

        #1;
        check("reset_flags", flags(), 4'h0);
        check("reset_sym", sym, 4'h0);
        ticks(3);
        check("reset_hold_flags", flags(), 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Clean press of btn[1].
        arm = 1'b1;
        tick();
        check("arm_busy", flags(), 4'h4);
        btn = 3'b010;
        ticks(6);
        check("t1_not_yet", sym_valid, 4'h0);
        tick();
        check("t1_valid", flags(), 4'h5);
        check("t1_sym", sym, 4'h1);
        ticks(3);
        check("t1_held", flags(), 4'h5);
        check("t1_held_sym", sym, 4'h1);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        check("t1_accept", flags(), 4'h4);
        btn = 3'b000;
        ticks(8);
        check("t1_released", flags(), 4'h4);

        // Multi-press, then a second press while still held.
        btn = 3'b101;
        ticks(7);
        check("t2_valid", flags(), 4'h5);
        check("t2_sym", sym, 4'h3);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        check("t2_accept", flags(), 4'h4);
        btn = 3'b111;
        ticks(10);
        check("t2_held_ignored", flags(), 4'h4);
        btn = 3'b000;
        ticks(7);
        check("t2_after_release", flags(), 4'h4);
        btn = 3'b001;
        ticks(7);
        check("t2_new_valid", flags(), 4'h5);
        check("t2_new_sym", sym, 4'h0);

        // Abort a pending symbol.
        ticks(2);
        arm = 1'b0;
        tick();
        check("abort_flags", flags(), 4'h0);
        btn = 3'b000;
        ticks(8);
        arm = 1'b1;
        tick();
        check("rearm_busy", flags(), 4'h4);
        ticks(5);
        check("rearm_no_stale", flags(), 4'h4);

        // Bouncing btn[0]: 3 high / 1 low for 20 cycles, then stable high.
        arm = 1'b0;
        tick();
        for (int r = 0; r < 5; r++) begin
            btn = 3'b001;
            ticks(3);
            btn = 3'b000;
            tick();
        end
        btn = 3'b001;
        arm = 1'b1;
        ticks(6);
        check("bounce_not_yet", flags(), 4'h4);
        tick();
        check("bounce_valid", flags(), 4'h5);
        check("bounce_sym", sym, 4'h0);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        check("bounce_accept", flags(), 4'h4);
        btn = 3'b000;
        ticks(8);
        arm = 1'b0;
        tick();

`ifdef BTN_CAPTURE_TIMEOUT_EN
        arm = 1'b1;
        tick();
        ticks(15);
        check("to1_not_yet", flags(), 4'h4);
        tick();
        check("to1_fire", flags(), 4'h7);
        check("to1_sym", sym, 4'h3);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        check("to1_accept", flags(), 4'h4);
        ticks(15);
        check("to2_not_yet", flags(), 4'h4);
        tick();
        check("to2_fire", flags(), 4'h7);
        check("to2_sym", sym, 4'h3);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        check("to2_accept", flags(), 4'h4);
        arm = 1'b0;
        tick();
`else
        arm = 1'b1;
        tick();
        ticks(40);
        check("no_timeout", flags(), 4'h4);
        arm = 1'b0;
        tick();
`endif

        // Reset while a symbol is held.
        arm = 1'b1;
        tick();
        btn = 3'b100;
        ticks(7);
        check("pre_reset_valid", flags(), 4'h5);
        check("pre_reset_sym", sym, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_flags", flags(), 4'h0);
        check("async_reset_sym", sym, 4'h0);
        btn = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", flags(), 4'h4);
        btn = 3'b100;
        ticks(7);
        check("post_reset_valid", flags(), 4'h5);
        check("post_reset_sym", sym, 4'h2);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        check("post_reset_accept", flags(), 4'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
